// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin requester client bank.
package rr_pkg;

  // Per-client controller state.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    OWN  = 2'b10
  } client_st_e;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 3;

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_client_ctrl.sv
// Single requester client: pending counter, request/ownership FSM,
// burst down-counter and sticky overflow flag.
//
// state | meaning
// IDLE  | nothing pending, req low
// REQ   | at least one transaction pending, req held until granted
// OWN   | owns the shared resource; burst counter runs down to 0
module rr_client_ctrl
  import rr_pkg::*;
#(
  parameter int CntW     = 3,
  parameter int BurstLen = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            post,
  input  logic            grant,
  output logic            req,
  output logic            own,
  output logic            done,
  output logic [CntW-1:0] pend_cnt,
  output logic            full,
  output logic            ovf
);

  localparam logic [CntW-1:0] CntMax    = '1;
  localparam logic [3:0]      BurstLoad = 4'(BurstLen - 1);

  client_st_e      state_q, state_d;
  logic [3:0]      burst_q, burst_d;
  logic [CntW-1:0] pend_d;
  logic            ovf_d;
  logic            accept;
  logic            inc;

  assign req  = (state_q == REQ);
  assign own  = (state_q == OWN);
  assign done = (state_q == OWN) && (burst_q == 4'd0);
  assign full = (pend_cnt == CntMax);

  // Pending count and overflow: a post that coincides with an accept cancels
  // out even when full; a lone post while full is dropped and flagged.
  always_comb begin
    accept = (state_q == REQ) && grant;
    inc    = post && (!full || accept);
    pend_d = pend_cnt;
    ovf_d  = ovf;
    if (inc && !accept) begin
      pend_d = pend_cnt + CntW'(1);
    end else if (accept && !inc) begin
      pend_d = pend_cnt - CntW'(1);
    end
    if (post && full && !accept) begin
      ovf_d = 1'b1;
    end
  end

  // Next-state and burst counter; the exit from OWN looks at the post-update
  // count so a post landing on the done cycle keeps the client requesting.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pend_cnt != '0) state_d = REQ;
      end
      REQ: begin
        if (grant) begin
          state_d = OWN;
          burst_d = BurstLoad;
        end
      end
      OWN: begin
        if (burst_q == 4'd0) begin
          state_d = (pend_d != '0) ? REQ : IDLE;
        end else begin
          burst_d = burst_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      burst_q  <= 4'd0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      pend_cnt <= pend_d;
      ovf      <= ovf_d;
    end
  end

endmodule

// File: rtl/rr_req_client_bank.sv
// Bank of requester clients feeding a round-robin arbiter, with a sticky
// checker for illegal grant/ownership patterns.
module rr_req_client_bank
  import rr_pkg::*;
#(
  parameter int NumReq   = NUM_REQ_DEF,
  parameter int CntW     = CNT_W_DEF,
  parameter int BurstLen = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NumReq-1:0]      post,
  input  logic [NumReq-1:0]      grant,
  output logic [NumReq-1:0]      req,
  output logic [NumReq-1:0]      own,
  output logic [NumReq-1:0]      done,
  output logic [NumReq*CntW-1:0] pend_cnt,
  output logic [NumReq-1:0]      full,
  output logic [NumReq-1:0]      ovf,
  output logic                   err
);

  logic viol;

  for (genvar g = 0; g < NumReq; g++) begin : g_client
    rr_client_ctrl #(
      .CntW     (CntW),
      .BurstLen (BurstLen)
    ) u_client (
      .clk      (clk),
      .rst      (rst),
      .post     (post[g]),
      .grant    (grant[g]),
      .req      (req[g]),
      .own      (own[g]),
      .done     (done[g]),
      .pend_cnt (pend_cnt[g*CntW +: CntW]),
      .full     (full[g]),
      .ovf      (ovf[g])
    );
  end

  // Violation: multi-hot grant, grant to a non-requester, or shared ownership.
  always_comb begin
    viol = !onehot0(32'(grant)) || (|(grant & ~req)) || !onehot0(32'(own));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err | viol;
    end
  end

endmodule

// File: tb/tb_rr_req_client_bank.sv
// Scoreboard bench for rr_req_client_bank with a behavioural client model
// and a round-robin arbiter model driving grant.
module tb_rr_req_client_bank;

  localparam int N    = 4;
  localparam int W    = 3;
  localparam int BL   = 2;
  localparam int MAXC = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] post, grant;
  logic [N-1:0] req, own, done, full, ovf;
  logic [N*W-1:0] pend_cnt;
  logic         err;

  rr_req_client_bank #(.NumReq(N), .CntW(W), .BurstLen(BL)) dut (
    .clk(clk), .rst(rst), .post(post), .grant(grant), .req(req), .own(own),
    .done(done), .pend_cnt(pend_cnt), .full(full), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: pending count, waiting flag, ownership cycles left.
  int m_cnt[N];
  bit m_wait[N];
  int m_left[N];
  bit m_ovf[N];
  bit m_err;
  int rr_last;

  typedef struct { int client; int due; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_wait[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_own();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_left[i] > 0);
    return v;
  endfunction

  function automatic logic [N-1:0] m_done();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_left[i] == 1);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_wait[i] = 0; m_left[i] = 0; m_ovf[i] = 0;
    end
    m_err = 0;
    rr_last = N - 1;
  endtask

  // Advance the model across one clock edge with inputs p and g.
  task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] g);
    logic [N-1:0] rq, ow;
    rq = m_req();
    ow = m_own();
    if ($countones(g) > 1 || (g & ~rq) != '0 || $countones(ow) > 1) m_err = 1;
    for (int i = 0; i < N; i++) begin
      bit acc;
      int nc;
      acc = m_wait[i] && g[i];
      nc = m_cnt[i];
      if (p[i] && acc) nc = m_cnt[i];
      else if (p[i]) begin
        if (m_cnt[i] == MAXC) m_ovf[i] = 1;
        else nc = m_cnt[i] + 1;
      end else if (acc) nc = m_cnt[i] - 1;
      if (m_left[i] > 0) begin
        if (m_left[i] == 1) begin
          m_left[i] = 0;
          m_wait[i] = (nc > 0);
        end else m_left[i] = m_left[i] - 1;
      end else if (m_wait[i]) begin
        if (acc) begin
          m_wait[i] = 0;
          m_left[i] = BL;
        end
      end else m_wait[i] = (m_cnt[i] > 0);
      m_cnt[i] = nc;
    end
  endtask

  task automatic compare_all();
    chk("req", req, m_req());
    chk("own", own, m_own());
    chk("done", done, m_done());
    chk("err", err, m_err);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pend%0d", i), pend_cnt[i*W +: W], m_cnt[i]);
      chk($sformatf("full%0d", i), full[i], m_cnt[i] == MAXC);
      chk($sformatf("ovf%0d", i), ovf[i], m_ovf[i]);
    end
  endtask

  // One cycle: drive at negedge, model the edge, compare at next negedge.
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] g);
    post = p;
    grant = g;
    for (int i = 0; i < N; i++)
      if (g[i] && m_wait[i]) sb.push_back('{i, cyc + BL});
    @(posedge clk);
    model_step(p, g);
    @(negedge clk);
    compare_all();
  endtask

  // Round-robin arbiter model; holds off while a burst has more than one cycle left.
  task automatic arb_pick(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < N; i++) if (m_left[i] > 1) return;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (rr_last + k) % N;
      if (m_wait[idx]) begin
        g[idx] = 1'b1;
        rr_last = idx;
        return;
      end
    end
  endtask

  task automatic run_arb(input int n, input int post_pct, input int grant_pct);
    repeat (n) begin
      logic [N-1:0] p, g;
      p = '0;
      g = '0;
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(99) < post_pct);
      if ($urandom_range(99) < grant_pct) arb_pick(g);
      step(p, g);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; starts and ends at a negedge.
  task automatic do_reset();
    post = '0;
    grant = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req", req, 0);
    chk("rst_own", own, 0);
    chk("rst_done", done, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    sb.delete();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest expected burst end.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst && done != '0) begin
        if (sb.size() == 0) chk("done_unexpected", done, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_done_client", done, 1 << e.client);
          chk("sb_done_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    post = '0;
    grant = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single client, burst then back to idle.
    step(4'b0001, '0);
    run_arb(8, 0, 100);

    // Three concurrent requesters in rotation.
    step(4'b0111, '0);
    run_arb(14, 0, 100);

    // Counter boundary on client 3.
    repeat (7) step(4'b1000, '0);
    chk("full3_at7", full[3], 1);
    step(4'b1000, 4'b1000);
    chk("pend3_post_accept", pend_cnt[9 +: 3], 7);
    chk("ovf3_not_set", ovf[3], 0);
    step(4'b1000, '0);
    chk("ovf3_set", ovf[3], 1);
    run_arb(40, 0, 100);

    // Back-to-back on client 2.
    do_reset();
    step(4'b0100, '0);
    step(4'b0100, '0);
    run_arb(12, 0, 100);

    // Reset in the first ownership cycle of client 1.
    step(4'b0010, '0);
    for (int k = 0; k < 10 && !own[1]; k++) run_arb(1, 0, 100);
    chk("own1_before_rst", own[1], 1);
    do_reset();
    repeat (4) step('0, '0);

    // Protocol violations.
    step('0, 4'b0011);
    chk("err_multi", err, 1);
    step('0, '0);
    do_reset();
    step('0, 4'b1000);
    chk("err_no_req", err, 1);
    repeat (2) step('0, '0);
    chk("err_sticky", err, 1);
    do_reset();

    // Randomized traffic, then drain.
    run_arb(600, 15, 70);
    run_arb(150, 0, 100);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/rr_req_client_bank.md
Name: rr_req_client_bank

Overview:
- Requester-side bank of NumReq client controllers that drives the req vector into the round-robin arbiter and consumes its grant vector.
- Each client queues posted transactions in a pending counter and raises req until granted.
- After a grant, each client owns the shared resource for BurstLen cycles, then pulses done.
- Also checks grant legality and flags protocol violations, making it the counterpart and traffic source for arbiter integration.

Parameters:
- NumReq, 4, number of clients; equals arbiter width.
- CntW, 3, pending-counter width; max pending = 2**CntW-1.
- BurstLen, 2, ownership cycles per grant; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- post  input  NumReq  per-client one-cycle pulse; enqueues one transaction.
- grant  input  NumReq  grant vector from the arbiter.
- req  output  NumReq  request vector to the arbiter.
- own  output  NumReq  client currently owns the resource (transfer cycles).
- done  output  NumReq  one-cycle pulse on the last ownership cycle.
- pend_cnt  output  NumReq*CntW  flattened pending counts; client i in bits [i*CntW +: CntW].
- full  output  NumReq  pend_cnt[i] == 2**CntW-1.
- ovf  output  NumReq  sticky; post received while full.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1):
  - States go to IDLE.
  - All pend_cnt=0.
  - req, own, done, full, ovf and err are all 0.
  - Reset mid-burst aborts the burst with no done pulse.
- Per-client FSM, registered state; states IDLE, REQ, OWN.
  - IDLE: if pend_cnt>0 at the clock edge, go to REQ. The post arriving that cycle counts only from the next cycle, so the first req appears 2 cycles after the first post.
  - REQ: req[i]=1, held continuously until grant[i]=1 is sampled.
  - On grant[i]=1 in REQ: go to OWN, pend_cnt decrements, burst counter loads BurstLen-1.
  - OWN: req[i]=0 and own[i]=1. The burst counter decrements each cycle. When the counter is 0, done[i]=1 (combinational from the registered state), and the next state is REQ if the post-update pend_cnt>0, else IDLE.
  - BurstLen=1: OWN lasts one cycle and done pulses in that cycle.
- Pending counter:
  - post alone: +1.
  - grant-accept alone: -1.
  - Both in the same cycle: unchanged.
  - post while full with no accept in that cycle: count unchanged and ovf[i] set (sticky until reset).
  - Counter never wraps.
- grant[i] is ignored in IDLE and OWN for state purposes; it does not change state or count.
- err is set (sticky) on any sampled cycle where:
  - grant has more than one bit set, or
  - grant[i]=1 while req[i]=0, or
  - any two own bits are set.
- No combinational path from grant to req. Outputs other than done are registered or decoded from registered state.

Decomposition:
- Package rr_pkg holds:
  - client-state enum (IDLE, REQ, OWN; 2-bit encoding 00/01/10);
  - default NumReq and CntW constants;
  - a function for one-hot-or-zero checking.
- One sub-module, rr_client_ctrl, is the single-client FSM + pending counter + burst counter + ovf. The bank instantiates it NumReq times via generate.
- The bank top holds only the err checker and port flattening.

Test Plan:
- Reset: assert rst mid-OWN of client 1 -> req=0000, own=0000, pend_cnt all 0, err=0 immediately (async); no done pulse.
- Single client: post[0] pulse at cycle 0; arbiter model grants 0001 at the first req cycle -> req[0] high at cycle 2; own[0] for 2 cycles; done[0] on the 2nd own cycle; pend_cnt[0] goes 1->0; state returns to IDLE.
- Concurrent: posts on clients 0,1,2 (pattern 0111) with real RoundRobin arbiter connected -> grants 0001, 0010, 0100 in rotation; each client gets exactly one own window; no own overlap; err=0.
- Counter boundary (CntW=3): 7 posts to client 3 -> full[3]=1. 8th post -> ovf[3]=1, count stays 7. Post coincident with a grant-accept -> count unchanged, ovf not newly set.
- Back-to-back: pend_cnt[2]=2, single grant each time req rises -> after the first done, req[2] re-asserts next cycle without passing through IDLE; after the second done, go to IDLE with count 0.
- Protocol violations: drive grant=0011 -> err=1. After reset, drive grant=1000 while req[3]=0 -> err=1. Both remain set until rst.
